// File: rtl/seq_detect_param.sv
// seq_detect_param: serial N-bit pattern detector (clk, rst_n, x/x_valid in; pat/pat_load reload; overlap_en; cnt_clr; y pulse and saturating match_cnt out)
module seq_detect_param #(
  parameter int N = 4,
  parameter logic [N-1:0] PAT_RESET = N'(4'b1010),
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             x,
  input  logic             x_valid,
  input  logic [N-1:0]     pat,
  input  logic             pat_load,
  input  logic             overlap_en,
  input  logic             cnt_clr,
  output logic             y,
  output logic [CNT_W-1:0] match_cnt
);
  localparam int FW = $clog2(N);
  localparam logic [FW-1:0] FULL = FW'(N - 1);
  logic [N-1:0] pat_q, pat_d, cand;
  logic [N-2:0] hist_q, hist_d;
  logic [FW-1:0] fill_q, fill_d;
  logic y_q, y_d, match, clear_hist;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    cand = {hist_q, x};
    match = x_valid & ~pat_load & (fill_q == FULL) & (cand == pat_q);
    clear_hist = pat_load | (match & ~overlap_en);
    pat_d = pat_load ? pat : pat_q;
    hist_d = clear_hist ? '0 : x_valid ? cand[N-2:0] : hist_q;
    fill_d = clear_hist ? '0 : (x_valid && fill_q != FULL) ? fill_q + 1'b1 : fill_q;
    y_d = match;
    cnt_d = cnt_clr ? '0 : (match && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q <= PAT_RESET;
      hist_q <= '0;
      fill_q <= '0;
      y_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      pat_q <= pat_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      y_q <= y_d;
      cnt_q <= cnt_d;
    end
  end
  assign y = y_q;
  assign match_cnt = cnt_q;
endmodule
